// File: rtl/imuldiv_muldiv_arb.sv
// Arbiter that lets two requesters share one in-order mul/div unit and routes each
// result back to its issuer. Define IMULDIV_MULDIV_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module imuldiv_muldiv_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req0_fn,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [2:0]  req1_fn,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [63:0] resp0_result,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [63:0] resp1_result,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [2:0]  muldivreq_msg_fn,
    output logic [31:0] muldivreq_msg_a,
    output logic [31:0] muldivreq_msg_b,
    output logic        muldivreq_val,
    input  logic        muldivreq_rdy,
    input  logic [63:0] muldivresp_msg_result,
    input  logic        muldivresp_val,
    output logic        muldivresp_rdy,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [DEPTH-1:0] owner_mem;
    logic             full;
    logic             empty;
    logic             pref;
    logic             grant0;
    logic             grant1;
    logic             head;
    logic             issue;
    logic             retire;

`ifdef IMULDIV_MULDIV_ARB_FIXED_PRIO_EN
    assign pref = 1'b0;
`else
    // pref = 1 means requester 1 wins a tie; flips to the loser after every issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pref <= 1'b0;
        end else if (issue) begin
            pref <= ~grant1;
        end
    end
`endif

    always_comb begin
        full   = (count == (AW+1)'(DEPTH));
        empty  = (count == '0);
        grant0 = req0_val & (~req1_val | ~pref);
        grant1 = req1_val & (~req0_val | pref);
        head   = owner_mem[rd_ptr];

        // every handshake output is gated by reset so nothing fires while it is held low
        muldivreq_val    = reset & (grant0 | grant1) & ~full;
        muldivreq_msg_fn = grant1 ? req1_fn : req0_fn;
        muldivreq_msg_a  = grant1 ? req1_a  : req0_a;
        muldivreq_msg_b  = grant1 ? req1_b  : req0_b;
        req0_rdy         = reset & grant0 & muldivreq_rdy & ~full;
        req1_rdy         = reset & grant1 & muldivreq_rdy & ~full;

        resp0_result   = muldivresp_msg_result;
        resp1_result   = muldivresp_msg_result;
        resp0_val      = reset & muldivresp_val & ~empty & ~head;
        resp1_val      = reset & muldivresp_val & ~empty & head;
        muldivresp_rdy = reset & ~empty & (head ? resp1_rdy : resp0_rdy);
        busy           = reset & ~empty;

        issue  = muldivreq_val & muldivreq_rdy;
        retire = muldivresp_val & muldivresp_rdy;
    end

    // owner FIFO control; DEPTH is a power of two so the pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({issue, retire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            owner_mem[wr_ptr] <= grant1;
        end
    end

endmodule

// File: tb/tb_imuldiv_muldiv_arb.sv
// Bench for imuldiv_muldiv_arb: combinational vector table, directed sequences and a
// randomized run against a queue-based reference of the arbiter and an in-order unit model.
module tb_imuldiv_muldiv_arb;
    localparam int DEPTH = 4;
`ifdef IMULDIV_MULDIV_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        reset;
    logic [2:0]  req0_fn, req1_fn;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_val, req1_val, req0_rdy, req1_rdy;
    logic [63:0] resp0_result, resp1_result;
    logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic        busy;

    imuldiv_muldiv_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_fn(req0_fn), .req0_a(req0_a), .req0_b(req0_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_fn(req1_fn), .req1_a(req1_a), .req1_b(req1_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_result(resp0_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_result(resp1_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy), .busy(busy)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    // reference state: owner order, issue preference, in-order unit and per-requester scoreboards
    bit          own_q[$];
    bit          pref;
    logic [63:0] unit_q[$];
    logic [63:0] exp_q0[$], exp_q1[$];
    logic [63:0] got0[$], got1[$];
    int          issue_log[$];
    bit          r1_seen;
    bit          unit_rdy, unit_resp_en;

    typedef struct {
        logic       rst;
        logic       v0;
        logic       v1;
        logic       mrdy;
        logic       mrv;
        logic       rr;
        logic [6:0] exp;
        logic       sel;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [6:0] dut_status();
        return {req0_rdy, req1_rdy, muldivreq_val, muldivresp_rdy, resp0_val, resp1_val, busy};
    endfunction

    function automatic logic [63:0] ref_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] q, r;
        logic [31:0] uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        q = 32'sd0; r = 32'sd0; uq = 32'd0; ur = 32'd0;
        if (b != 32'd0) begin
            q  = $signed(a) / $signed(b);
            r  = $signed(a) % $signed(b);
            uq = a / b;
            ur = a % b;
        end
        case (fn)
            3'd0:       return sa * sb;
            3'd1, 3'd3: return {r, q};
            3'd2, 3'd4: return {ur, uq};
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 64'hbad0_bad0_bad0_bad0;
    endfunction

    task automatic clear_logs();
        got0.delete(); got1.delete(); issue_log.delete(); r1_seen = 1'b0;
    endtask

    // one clock: drive unit side, compare against the reference, then advance the reference
    task automatic cycle();
        bit full, empty, head, g0, g1, do_issue, do_pop, h;
        logic [6:0] e;
        logic [63:0] res, want;
        muldivreq_rdy         = unit_rdy;
        muldivresp_val        = unit_resp_en && (unit_q.size() != 0);
        muldivresp_msg_result = (unit_q.size() != 0) ? unit_q[0] : 64'd0;
        #1;
        full  = (own_q.size() == DEPTH);
        empty = (own_q.size() == 0);
        head  = empty ? 1'b0 : own_q[0];
        g0 = req0_val && (!req1_val || !pref);
        g1 = req1_val && (!req0_val || pref);
        e = {g0 && muldivreq_rdy && !full, g1 && muldivreq_rdy && !full, (g0 || g1) && !full,
             !empty && (head ? resp1_rdy : resp0_rdy),
             muldivresp_val && !empty && !head, muldivresp_val && !empty && head, !empty};
        chk("status", 64'(dut_status()), 64'(e));
        if (e[4]) begin
            chk("msg_fn", 64'(muldivreq_msg_fn), 64'(g1 ? req1_fn : req0_fn));
            chk("msg_ab", {muldivreq_msg_a, muldivreq_msg_b}, g1 ? {req1_a, req1_b} : {req0_a, req0_b});
        end
        if (resp1_val) r1_seen = 1'b1;
        do_issue = e[4] && muldivreq_rdy;
        do_pop   = muldivresp_val && e[3];
        if (do_pop) begin
            h = own_q.pop_front();
            void'(unit_q.pop_front());
            res  = h ? resp1_result : resp0_result;
            want = h ? exp_q1.pop_front() : exp_q0.pop_front();
            chk(h ? "resp1_data" : "resp0_data", res, want);
            if (h) got1.push_back(res); else got0.push_back(res);
        end
        if (do_issue) begin
            res = g1 ? ref_op(req1_fn, req1_a, req1_b) : ref_op(req0_fn, req0_a, req0_b);
            unit_q.push_back(res);
            own_q.push_back(g1);
            if (g1) exp_q1.push_back(res); else exp_q0.push_back(res);
            issue_log.push_back(g1 ? 1 : 0);
            pref = FIXED ? 1'b0 : !g1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1; unit_resp_en = 1'b1;
        for (int i = 0; i < 60 && own_q.size() != 0; i++) cycle();
        chk({name, "_drained"}, 64'(own_q.size()), 64'd0);
        cycle();
    endtask

    task automatic rand_ops(output logic [2:0] fn, output logic [31:0] a, output logic [31:0] b);
        fn = 3'($urandom_range(4, 0));
        a  = $urandom;
        b  = (($urandom & 1) != 0) ? $urandom : 32'($urandom_range(40, 1));
        if (b == 32'd0) b = 32'd1;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) b = 32'd3;
    endtask

    initial begin
        reset = 1'b0;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_fn = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_fn = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        muldivreq_rdy = 1'b0; muldivresp_val = 1'b0; muldivresp_msg_result = 64'd0;
        unit_rdy = 1'b0; unit_resp_en = 1'b0; pref = 1'b0; r1_seen = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1010000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0110000, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1010000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1010000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_status", 64'(dut_status()), 64'd0);
        reset = 1'b1;
        clk_run = 1'b0;
        #2;

        // clock stopped: fresh state (empty, requester 0 preferred), pure combinational checks
        req0_fn = 3'd2; req0_a = 32'h11; req0_b = 32'h22;
        req1_fn = 3'd4; req1_a = 32'h33; req1_b = 32'h44;
        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst;
            req0_val = vecs[i].v0; req1_val = vecs[i].v1;
            muldivreq_rdy = vecs[i].mrdy; muldivresp_val = vecs[i].mrv;
            resp0_rdy = vecs[i].rr; resp1_rdy = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d_status", i), 64'(dut_status()), 64'(vecs[i].exp));
            if (vecs[i].exp[4]) begin
                chk($sformatf("vec%0d_fn", i), 64'(muldivreq_msg_fn), 64'(vecs[i].sel ? req1_fn : req0_fn));
                chk($sformatf("vec%0d_ab", i), {muldivreq_msg_a, muldivreq_msg_b},
                    vecs[i].sel ? {req1_a, req1_b} : {req0_a, req0_b});
            end
        end
        reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0;
        muldivreq_rdy = 1'b0; muldivresp_val = 1'b0;
        clk_run = 1'b1;
        @(negedge clk);

        // both requesters valid every cycle
        clear_logs();
        unit_rdy = 1'b1; unit_resp_en = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        req0_val = 1'b1; req0_fn = 3'd0; req0_a = 32'h8;   req0_b = 32'h3;
        req1_val = 1'b1; req1_fn = 3'd1; req1_a = 32'h222; req1_b = 32'h2a;
        repeat (4) cycle();
        req0_val = 1'b0;
        cycle();
        drain("rr");
        chk("rr_issue_count", 64'(issue_log.size()), 64'd5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_grant%0d", i), 64'((i < issue_log.size()) ? issue_log[i] : 9),
                64'(FIXED ? 0 : (i % 2)));
        chk("rr_grant_req1_alone", 64'((issue_log.size() > 4) ? issue_log[4] : 9), 64'd1);
        chk("rr_resp0", qat(got0, 0), 64'h18);
        chk("rr_resp1", qat(got1, 0), 64'hd);

        // single requester, negative multiply
        clear_logs();
        req0_val = 1'b1; req0_fn = 3'd0; req0_a = 32'hffff_fff8; req0_b = 32'h8;
        cycle();
        drain("solo");
        chk("solo_resp0", qat(got0, 0), 64'hffff_ffff_ffff_ffc0);
        chk("solo_resp1_never", 64'(r1_seen), 64'd0);

        // fill the owner FIFO with responses blocked, then drain in order
        clear_logs();
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        req0_val = 1'b1; req0_fn = 3'd0; req0_a = 32'd1; req0_b = 32'd3;
        for (int i = 0; i < 8; i++) begin
            automatic int n = issue_log.size();
            cycle();
            if (issue_log.size() > n) req0_a = req0_a + 32'd1;
        end
        chk("full_issued", 64'(issue_log.size()), 64'd4);
        #1;
        chk("full_req0_rdy", 64'(req0_rdy), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        resp0_rdy = 1'b1;
        for (int i = 0; i < 40 && issue_log.size() < 6; i++) begin
            automatic int n = issue_log.size();
            cycle();
            if (issue_log.size() > n) req0_a = req0_a + 32'd1;
        end
        drain("full");
        chk("full_resp_count", 64'(got0.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("full_resp%0d", i), qat(got0, i), 64'(3 * (i + 1)));

        // head owner stalls: no reordering past it
        clear_logs();
        unit_resp_en = 1'b0;
        req1_val = 1'b1; req1_fn = 3'd2; req1_a = 32'd100; req1_b = 32'd7;
        cycle();
        req1_val = 1'b0;
        req0_val = 1'b1; req0_fn = 3'd0; req0_a = 32'd5; req0_b = 32'd6;
        cycle();
        req0_val = 1'b0;
        resp1_rdy = 1'b0; resp0_rdy = 1'b1; unit_resp_en = 1'b1;
        repeat (3) cycle();
        #1;
        chk("stall_mresp_rdy", 64'(muldivresp_rdy), 64'd0);
        chk("stall_resp0_val", 64'(resp0_val), 64'd0);
        chk("stall_no_resp", 64'(got0.size() + got1.size()), 64'd0);
        drain("stall");
        chk("stall_resp1", qat(got1, 0), 64'h0000_0002_0000_000e);
        chk("stall_resp0", qat(got0, 0), 64'h1e);

        // reset with operations in flight
        clear_logs();
        unit_resp_en = 1'b0;
        req0_val = 1'b1; req0_fn = 3'd0; req0_a = 32'd2; req0_b = 32'd2;
        repeat (3) cycle();
        chk("rst_inflight", 64'(own_q.size()), 64'd3);
        #2;
        reset = 1'b0;
        muldivreq_rdy = 1'b1; muldivresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        #1;
        chk("rst_outputs", 64'(dut_status()), 64'd0);
        own_q.delete(); unit_q.delete(); exp_q0.delete(); exp_q1.delete(); pref = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req0_val = 1'b0;
        reset = 1'b1;
        unit_resp_en = 1'b1;
        req1_val = 1'b1; req1_fn = 3'd4; req1_a = 32'h222; req1_b = 32'h32;
        cycle();
        req1_val = 1'b0;
        drain("post_rst");
        chk("post_rst_resp1", qat(got1, 0), 64'h0000_002e_0000_000a);
        chk("post_rst_resp0_none", 64'(got0.size()), 64'd0);

        // randomized traffic
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            req0_val = 1'($urandom_range(1, 0));
            req1_val = 1'($urandom_range(1, 0));
            rand_ops(req0_fn, req0_a, req0_b);
            rand_ops(req1_fn, req1_a, req1_b);
            resp0_rdy = ($urandom_range(3, 0) != 0);
            resp1_rdy = ($urandom_range(3, 0) != 0);
            unit_rdy = ($urandom_range(3, 0) != 0);
            unit_resp_en = ($urandom_range(2, 0) != 0);
            cycle();
        end
        unit_rdy = 1'b1;
        drain("random");
        chk("random_issued", 64'(issue_log.size() > 50), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imuldiv_muldiv_arb.md
IMULDIV_MULDIV_ARB -- requirements
Module: imuldiv_muldiv_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the maximum in-flight operations tracked; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_fn / req1_fn, input, 3 bits: opcode (0 mul, 1 div, 2 divu, 3 rem, 4 remu).
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 bits: operands.
REQ-006 SHALL have ports req0_val / req1_val (input) and req0_rdy / req1_rdy (output), 1 bit each: requester handshake.
REQ-007 SHALL have ports resp0_result / resp1_result, output, 64 bits: {hi/rem, lo/quot} result.
REQ-008 SHALL have ports resp0_val / resp1_val (output) and resp0_rdy / resp1_rdy (input), 1 bit each.
REQ-009 SHALL have ports muldivreq_msg_fn (3), muldivreq_msg_a (32), muldivreq_msg_b (32), muldivreq_val (1), all output, plus muldivreq_rdy, input, 1 bit: the shared-unit request side.
REQ-010 SHALL have ports muldivresp_msg_result, input, 64 bits, muldivresp_val, input, 1 bit, and muldivresp_rdy, output, 1 bit.
REQ-011 SHALL have port busy, output, 1 bit: high when the owner FIFO is non-empty.

Function
REQ-012 SHALL grant at most one requester per cycle, combinationally from the current req*_val and the priority pointer.
REQ-013 SHALL grant the sole valid requester when only one is valid, and the pointer's preferred requester when both are valid.
REQ-014 SHALL drive muldivreq_val = granted val AND NOT full, with fn/a/b muxed from the granted requester.
REQ-015 SHALL drive reqN_rdy = grantN AND muldivreq_rdy AND NOT full; the ungranted requester sees rdy = 0.
REQ-016 SHALL, on an issue fire (muldivreq_val AND muldivreq_rdy), push the granted requester ID into a DEPTH-entry owner FIFO and set the pointer to prefer the other requester.
REQ-017 SHALL block all issue while the FIFO holds DEPTH entries, even when a pop occurs in the same cycle.
REQ-018 SHALL route the unit's response to the head owner: respH_val = muldivresp_val AND NOT empty, respH_result = muldivresp_msg_result; the other resp val = 0.
REQ-019 SHALL drive muldivresp_rdy = NOT empty AND the head owner's resp rdy.
REQ-020 SHALL pop the FIFO on a response fire, with zero added latency in either direction.
REQ-021 SHALL, when a push and a pop occur in one cycle on a non-full FIFO, leave the count unchanged and keep entry order intact.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL leave a response arriving while the FIFO is empty un-accepted; this is protocol misuse.
REQ-024 SHALL keep requests and responses strictly in order; the unit is in-order.

Reset
REQ-025 SHALL, on reset assertion, immediately empty the FIFO, set the pointer to prefer requester 0, and force busy = 0.
REQ-026 SHALL force all val and rdy outputs to 0 while reset is low.
REQ-027 SHALL not preserve any in-flight operation across reset; the shared unit is reset by the same signal.

Configuration
REQ-028 SHALL, when macro IMULDIV_MULDIV_ARB_FIXED_PRIO_EN is defined, always prefer requester 0, with the pointer absent.
REQ-029 SHALL, when the macro is undefined, use round-robin per REQ-013/REQ-016.

Verification
REQ-030 SHALL cover: req0 only, mul a=0xfffffff8 b=0x8 -> resp0 result 0xffffffff_ffffffc0, resp1_val never 1.
REQ-031 SHALL cover: both valid every cycle, round-robin, req0 mul 0x8*0x3 and req1 div 0x222/0x2a -> grants alternate 0,1,0,1; resp0 0x18, resp1 0xd in issue order.
REQ-032 SHALL cover: DEPTH=4, resp rdy held 0, 6 requests offered -> exactly 4 issue, then req rdy = 0 and busy = 1; releasing rdy drains all in order.
REQ-033 SHALL cover: head owner resp1_rdy = 0 while resp0_rdy = 1 -> muldivresp_rdy = 0, no reordering, resp0 waits.
REQ-034 SHALL cover: reset low with 3 ops in flight -> busy = 0 and all val = 0 immediately; after release a new remu 0x222/0x32 returns 0x2e_0000000a to its issuer.
REQ-035 SHALL cover: with IMULDIV_MULDIV_ARB_FIXED_PRIO_EN defined and both valid -> 4 consecutive grants to req0, req1 granted only when req0_val = 0.
